// File: rtl/bist_pkg.sv
// Constants and types shared by the LBIST pattern generator, MISR and signature comparator.
package bist_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } bist_state_t;

    localparam int unsigned DEFAULT_BITS = 8;

    // x^8 + x^4 + x^3 + x^2 + 1
    localparam logic [DEFAULT_BITS-1:0] POLY_DEFAULT = 8'h1D;
    localparam logic [DEFAULT_BITS-1:0] SEED_DEFAULT = 8'h00;

endpackage

// File: rtl/misr_core.sv
// MISR datapath: seed load, shift/XOR compaction of one word, otherwise hold.
module misr_core #(
    parameter int unsigned     BITS = 8,
    parameter logic [BITS-1:0] POLY = 8'h1D,
    parameter logic [BITS-1:0] SEED = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            shift,
    input  logic [BITS-1:0] d,
    output logic [BITS-1:0] sig
);

    logic [BITS-1:0] next_sig;

    // Galois-style step: shift left, fold the MSB back through the taps, absorb the word.
    always_comb begin
        next_sig = {sig[BITS-2:0], 1'b0} ^ (sig[BITS-1] ? POLY : '0) ^ d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig <= SEED;
        end else if (load) begin
            sig <= SEED;
        end else if (shift) begin
            sig <= next_sig;
        end
    end

endmodule

// File: rtl/bist_misr.sv
// LBIST MISR with session control (IDLE/RUN/DONE) feeding the signature comparator.
// Optional BIST_XMASK_EN adds an x_mask port that zeroes unknown response bits before compaction.
module bist_misr
    import bist_pkg::*;
#(
    parameter int unsigned     BITS         = 8,
    parameter logic [BITS-1:0] POLY         = BITS'(POLY_DEFAULT),
    parameter logic [BITS-1:0] SEED         = BITS'(SEED_DEFAULT),
    parameter int unsigned     NUM_PATTERNS = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            d_valid,
    input  logic [BITS-1:0] d_in,
`ifdef BIST_XMASK_EN
    input  logic [BITS-1:0] x_mask,
`endif
    output logic            busy,
    output logic            done,
    output logic [BITS-1:0] sig
);

    localparam int unsigned   CW   = $clog2(NUM_PATTERNS + 1);
    localparam logic [CW-1:0] LAST = CW'(NUM_PATTERNS - 1);

    bist_state_t     state;
    logic [CW-1:0]   count;
    logic            load_c;
    logic            shift_c;
    logic [BITS-1:0] data_c;

    // Start is only honoured outside RUN; a beat arriving with start is never compacted.
    always_comb begin
        load_c  = (state != RUN) && start;
        shift_c = (state == RUN) && d_valid;
`ifdef BIST_XMASK_EN
        data_c  = d_in & ~x_mask;
`else
        data_c  = d_in;
`endif
    end

    // Session FSM with beat counter; busy/done registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            count <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state <= RUN;
                        count <= '0;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                    end
                end
                RUN: begin
                    if (d_valid) begin
                        if (count == LAST) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            count <= count + CW'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    count <= '0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    misr_core #(
        .BITS (BITS),
        .POLY (POLY),
        .SEED (SEED)
    ) u_core (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load_c),
        .shift (shift_c),
        .d     (data_c),
        .sig   (sig)
    );

endmodule

// File: doc/bist_misr.md
# bist_misr

Multiple-input signature register (MISR) with session control for the LBIST datapath. It compacts a fixed number of circuit-under-test response words into a BITS-wide signature and presents the final signature, with a done flag, to the downstream signature comparator. It sits between the CUT outputs and the equality comparator and is the producing end of the signature-compare interface.

## Interface

- BITS, 8: signature and response width; must be ≥ 2.
- POLY, 8'h1D: feedback polynomial taps (x^8+x^4+x^3+x^2+1), BITS wide.
- SEED, 0: signature value loaded at reset and at every session start.
- NUM_PATTERNS, 255: number of valid response words compacted per session; must be ≥ 1.

- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- start  in  1  single-cycle session start request.
- d_valid  in  1  d_in carries a CUT response word this cycle.
- d_in  in  BITS  CUT response word.
- busy  out  1  session in progress.
- done  out  1  signature final and stable; comparator may sample sig.
- sig  out  BITS  current signature register.

## Operation

- States: IDLE, RUN, DONE.
- Reset (any state, any time): state=IDLE, sig=SEED, count=0, busy=0, done=0.
- IDLE: start=1 → RUN, sig←SEED, count←0. d_valid is ignored.
- RUN: busy=1. On each edge with d_valid=1: sig←{sig[BITS-2:0],1'b0} ^ (sig[BITS-1] ? POLY : 0) ^ d_in, count←count+1. If d_valid=0, sig and count hold.
- RUN → DONE on the edge that captures beat NUM_PATTERNS (count==NUM_PATTERNS-1 with d_valid=1).
- DONE: done=1, busy=0, sig frozen. d_valid ignored. Stays in DONE until start=1 → RUN with sig←SEED, count←0, done←0.
- start while in RUN is ignored; the session is not restarted.
- count width is $clog2(NUM_PATTERNS+1); count never exceeds NUM_PATTERNS-1 in RUN.
- All arithmetic is XOR within BITS; no carry, no overflow.

## Timing

- All outputs are registered; no combinational input→output path.
- start at edge N → busy=1 after edge N; the first beat may be captured at edge N+1.
- Last beat captured at edge M → sig holds the final value and done=1 after edge M, in the same cycle; busy=0 the same cycle.
- Compaction throughput: one word per cycle; gaps allowed via d_valid=0.
- Reset mid-RUN aborts the session immediately; the partial signature is discarded (sig=SEED).
- start and d_valid high together in IDLE or DONE: only start acts; that beat is not compacted.

## Configuration

- BIST_XMASK_EN defined: adds input port x_mask (BITS, after d_in). Bits set in x_mask are forced to 0 in d_in before compaction, to block unknown CUT outputs. Masking applies only in RUN.
- Not defined: no x_mask port, and d_in is compacted unmodified.

## Structure

- Shared package bist_pkg holds the state typedef (IDLE/RUN/DONE), the default polynomial constant for BITS=8, and the default SEED constant, so the pattern generator and comparator can use the same constants.
- One sub-module: misr_core, the pure datapath (load, shift/XOR update, hold) with BITS/POLY/SEED parameters. bist_misr contains the FSM, the counter and the masking.

## Test plan

- Reset release, no start → sig=0x00, busy=0, done=0 held for 10 cycles even with d_valid=1, d_in=0xFF.
- NUM_PATTERNS=3, start, d_in=0x01 valid on 3 consecutive cycles → sig 0x01, 0x03, 0x07; done=1 with sig=0x07 after the third capture.
- NUM_PATTERNS=2, d_in=0x80 twice → sig 0x80 then 0x9D (feedback path); done=1.
- NUM_PATTERNS=3, valid beats 0x01, gap of 2 cycles with d_valid=0, then 0x01, 0x01 → final sig=0x07; done is not asserted during the gap.
- rst_n pulsed low after 1 beat, while in RUN → immediately sig=0x00, busy=0, done=0; a new start runs a full session correctly.
- With BIST_XMASK_EN and x_mask=0x80, NUM_PATTERNS=2, d_in=0x80 twice → final sig=0x00.
